// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: issues sequential ROM reads, buffers words in a DEPTH-entry FIFO,
// flushes on redirect. Optional macro IFQ_BYPASS_EN forwards a response straight to the core when empty.
module ifetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ROM_AW = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic              insn_valid,
  input  logic              insn_ready,
  output logic [31:0]       insn,
  output logic [31:0]       insn_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } entry_t;

  entry_t [DEPTH-1:0] q_mem;
  logic [PW-1:0]      rd_ptr, wr_ptr;
  logic [CW-1:0]      count, credit;
  logic [31:0]        fetch_pc, fetch_pc_nxt, inflight_pc;
  logic               inflight, issue, resp, push, pop, q_empty;
  logic               unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  // An in-flight read already owns a slot, so it counts against the credit.
  assign credit  = count + CW'(inflight);
  assign issue   = !redirect && (credit < CW'(DEPTH));
  assign resp    = inflight && !redirect;
  assign q_empty = (count == '0);
  assign pop     = !q_empty && insn_ready;

`ifdef IFQ_BYPASS_EN
  logic byp;
  assign byp        = q_empty && resp;
  assign insn_valid = !q_empty || byp;
  assign insn       = byp ? rom_data    : q_mem[rd_ptr].word;
  assign insn_pc    = byp ? inflight_pc : q_mem[rd_ptr].pc;
  // A bypassed word the core takes immediately never occupies the queue.
  assign push       = resp && !(byp && insn_ready);
`else
  assign insn_valid = !q_empty;
  assign insn       = q_mem[rd_ptr].word;
  assign insn_pc    = q_mem[rd_ptr].pc;
  assign push       = resp;
`endif

  always_comb begin
    fetch_pc_nxt = fetch_pc;
    if (redirect)   fetch_pc_nxt = {redirect_pc[31:2], 2'b00};
    else if (issue) fetch_pc_nxt = fetch_pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= '0;
      rom_addr    <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      q_mem       <= '0;
    end else begin
      fetch_pc <= fetch_pc_nxt;
      rom_addr <= fetch_pc_nxt[ROM_AW+1:2];
      inflight <= issue;
      if (issue) inflight_pc <= fetch_pc;
      if (redirect) begin
        // Flush wins over any same-cycle pop or response.
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          q_mem[wr_ptr] <= '{word: rom_data, pc: inflight_pc};
          wr_ptr        <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: synchronous ROM model with ROM[i] = 0x1000 + i.
// Expectations are written against the fetch latency LAT (2, or 1 with IFQ_BYPASS_EN).
module tb_ifetch_queue;
  localparam int DEPTH  = 4;
  localparam int ROM_AW = 7;
`ifdef IFQ_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              redirect = 1'b0;
  logic [31:0]       redirect_pc = '0;
  logic [ROM_AW-1:0] rom_addr;
  logic [31:0]       rom_data = '0;
  logic              insn_valid;
  logic              insn_ready = 1'b0;
  logic [31:0]       insn, insn_pc;
  logic [31:0]       rom [128];

  int checks = 0;
  int failures = 0;

  ifetch_queue #(.DEPTH(DEPTH), .ROM_AW(ROM_AW)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .rom_addr(rom_addr), .rom_data(rom_data), .insn_valid(insn_valid),
    .insn_ready(insn_ready), .insn(insn), .insn_pc(insn_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  initial for (int i = 0; i < 128; i++) rom[i] = 32'h1000 + i;

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1; redirect = 1'b0; insn_ready = 1'b0;
    step; step;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
    step; step;
    checks++; if (insn_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", insn_valid); end
    checks++; if (rom_addr !== '0) begin failures++; $display("FAIL reset_rom_addr got=%0h exp=0", rom_addr); end
    checks++; if (insn !== 32'h0) begin failures++; $display("FAIL reset_insn got=%0h exp=0", insn); end
    checks++; if (insn_pc !== 32'h0) begin failures++; $display("FAIL reset_insn_pc got=%0h exp=0", insn_pc); end
    rst = 1'b0; redirect = 1'b0;
  endtask

  task automatic test_stream;
    do_reset;
    insn_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      checks++; if (rom_addr !== 7'(c)) begin failures++; $display("FAIL stream_rom_addr c=%0d got=%0d exp=%0d", c, rom_addr, c); end
      if (c < LAT) begin
        checks++; if (insn_valid !== 1'b0) begin failures++; $display("FAIL stream_early_valid c=%0d got=%0h exp=0", c, insn_valid); end
      end else begin
        checks++; if (insn_valid !== 1'b1 || insn !== 32'h1000 + 32'(c - LAT) || insn_pc !== 32'(4 * (c - LAT)))
          begin failures++; $display("FAIL stream_head c=%0d got=%0h/%0h@%0h exp=1/%0h@%0h", c, insn_valid, insn, insn_pc, 32'h1000 + 32'(c - LAT), 4 * (c - LAT)); end
      end
      step;
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    insn_ready = 1'b0;
    repeat (10) step;
    checks++; if (insn_valid !== 1'b1 || insn_pc !== 32'h0 || insn !== 32'h1000)
      begin failures++; $display("FAIL bp_full_head got=%0h/%0h@%0h exp=1/1000@0", insn_valid, insn, insn_pc); end
    checks++; if (rom_addr !== 7'd4) begin failures++; $display("FAIL bp_no_issue got=%0d exp=4", rom_addr); end
    step;
    checks++; if (rom_addr !== 7'd4 || insn !== 32'h1000) begin failures++; $display("FAIL bp_hold got=%0d/%0h exp=4/1000", rom_addr, insn); end
    insn_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step;
      checks++; if (insn_valid !== 1'b1 || insn_pc !== 32'(4 * k) || insn !== 32'h1000 + 32'(k))
        begin failures++; $display("FAIL bp_drain k=%0d got=%0h/%0h@%0h exp=1/%0h@%0h", k, insn_valid, insn, insn_pc, 32'h1000 + 32'(k), 4 * k); end
    end
  endtask

  task automatic test_redirect;
    do_reset;
    insn_ready = 1'b0;
    repeat (4) step;
    checks++; if (insn_valid !== 1'b1 || insn_pc !== 32'h0) begin failures++; $display("FAIL redir_pre got=%0h@%0h exp=1@0", insn_valid, insn_pc); end
    redirect = 1'b1; redirect_pc = 32'h40;
    step;
    checks++; if (insn_valid !== 1'b0) begin failures++; $display("FAIL redir_n1_valid got=%0h exp=0", insn_valid); end
    checks++; if (rom_addr !== 7'd16) begin failures++; $display("FAIL redir_rom_addr got=%0d exp=16", rom_addr); end
    redirect = 1'b0;
    for (int d = 2; d <= 3; d++) begin
      step;
      if (d < 1 + LAT) begin
        checks++; if (insn_valid !== 1'b0) begin failures++; $display("FAIL redir_gap d=%0d got=%0h exp=0", d, insn_valid); end
      end else begin
        checks++; if (insn_valid !== 1'b1 || insn !== 32'h1010 || insn_pc !== 32'h40)
          begin failures++; $display("FAIL redir_head d=%0d got=%0h/%0h@%0h exp=1/1010@40", d, insn_valid, insn, insn_pc); end
      end
    end
  endtask

  task automatic test_redirect_pop;
    int wait_n;
    do_reset;
    insn_ready = 1'b1;
    repeat (3) step;
    checks++; if (insn_valid !== 1'b1) begin failures++; $display("FAIL rpop_pre_valid got=%0h exp=1", insn_valid); end
    redirect = 1'b1; redirect_pc = 32'h43;
    step;
    redirect = 1'b0;
    checks++; if (insn_valid !== 1'b0) begin failures++; $display("FAIL rpop_n1_valid got=%0h exp=0", insn_valid); end
    wait_n = 0;
    while (insn_valid !== 1'b1 && wait_n < 8) begin step; wait_n++; end
    checks++; if (wait_n !== LAT) begin failures++; $display("FAIL rpop_latency got=%0d exp=%0d", wait_n, LAT); end
    checks++; if (insn_valid !== 1'b1 || insn_pc !== 32'h40 || insn !== 32'h1010)
      begin failures++; $display("FAIL rpop_head got=%0h/%0h@%0h exp=1/1010@40", insn_valid, insn, insn_pc); end
  endtask

  task automatic test_wrap;
    do_reset;
    insn_ready = 1'b1;
    step;
    redirect = 1'b1; redirect_pc = 32'h1FC;
    step;
    checks++; if (rom_addr !== 7'd127) begin failures++; $display("FAIL wrap_addr_hi got=%0d exp=127", rom_addr); end
    redirect = 1'b0;
    step;
    checks++; if (rom_addr !== 7'd0) begin failures++; $display("FAIL wrap_addr_lo got=%0d exp=0", rom_addr); end
    repeat (LAT - 1) step;
    checks++; if (insn_valid !== 1'b1 || insn !== 32'h107F || insn_pc !== 32'h1FC)
      begin failures++; $display("FAIL wrap_first got=%0h/%0h@%0h exp=1/107f@1fc", insn_valid, insn, insn_pc); end
    step;
    checks++; if (insn_valid !== 1'b1 || insn !== 32'h1000 || insn_pc !== 32'h200)
      begin failures++; $display("FAIL wrap_second got=%0h/%0h@%0h exp=1/1000@200", insn_valid, insn, insn_pc); end
  endtask

  task automatic test_back_to_back;
    int wait_n;
    do_reset;
    insn_ready = 1'b1;
    repeat (3) step;
    redirect = 1'b1; redirect_pc = 32'h80;
    step;
    checks++; if (insn_valid !== 1'b0) begin failures++; $display("FAIL b2b_n1_valid got=%0h exp=0", insn_valid); end
    redirect_pc = 32'h100;
    step;
    checks++; if (insn_valid !== 1'b0) begin failures++; $display("FAIL b2b_n2_valid got=%0h exp=0", insn_valid); end
    checks++; if (rom_addr !== 7'd64) begin failures++; $display("FAIL b2b_rom_addr got=%0d exp=64", rom_addr); end
    redirect = 1'b0;
    wait_n = 0;
    while (insn_valid !== 1'b1 && wait_n < 8) begin step; wait_n++; end
    checks++; if (wait_n !== LAT) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", wait_n, LAT); end
    checks++; if (insn_pc !== 32'h100 || insn !== 32'h1040)
      begin failures++; $display("FAIL b2b_head got=%0h@%0h exp=1040@100", insn, insn_pc); end
  endtask

  task automatic test_reset_mid;
    int wait_n;
    do_reset;
    insn_ready = 1'b1;
    repeat (5) step;
    rst = 1'b1;
    step;
    checks++; if (insn_valid !== 1'b0 || rom_addr !== '0 || insn_pc !== 32'h0)
      begin failures++; $display("FAIL rmid_state got=%0h/%0d@%0h exp=0/0@0", insn_valid, rom_addr, insn_pc); end
    rst = 1'b0;
    wait_n = 0;
    while (insn_valid !== 1'b1 && wait_n < 8) begin step; wait_n++; end
    checks++; if (wait_n !== LAT) begin failures++; $display("FAIL rmid_latency got=%0d exp=%0d", wait_n, LAT); end
    checks++; if (insn !== 32'h1000 || insn_pc !== 32'h0)
      begin failures++; $display("FAIL rmid_head got=%0h@%0h exp=1000@0", insn, insn_pc); end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_redirect;
    test_redirect_pop;
    test_wrap;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning prefetch queue entries (power of two, 2..16).
REQ-002 SHALL have parameter ROM_AW, default 7, meaning ROM word-address width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port redirect  input  1  flush request from core (JAL/JALR taken).
REQ-006 SHALL have port redirect_pc  input  32  new fetch byte address; bits [1:0] ignored.
REQ-007 SHALL have port rom_addr  output  ROM_AW  word address presented to ROM.
REQ-008 SHALL have port rom_data  input  32  ROM read data for the rom_addr of the previous cycle.
REQ-009 SHALL have port insn_valid  output  1  queue head holds a valid instruction.
REQ-010 SHALL have port insn_ready  input  1  core accepts head this cycle.
REQ-011 SHALL have port insn  output  32  head instruction word.
REQ-012 SHALL have port insn_pc  output  32  byte address of head instruction.

Function
REQ-013 SHALL keep fetch_pc (32 b); rom_addr SHALL equal fetch_pc[ROM_AW+1:2], registered.
REQ-014 SHALL issue a read in a cycle only when count + inflight < DEPTH and redirect is low; on issue fetch_pc += 4, modulo 2^32; rom_addr wraps naturally at 2^ROM_AW words.
REQ-015 SHALL track one in-flight read (inflight flag + inflight_pc); response arrives exactly one cycle after issue.
REQ-016 SHALL enqueue {rom_data, inflight_pc} at end of the response cycle unless squashed.
REQ-017 SHALL assert insn_valid iff count != 0; insn/insn_pc SHALL show the head entry.
REQ-018 SHALL pop on insn_valid & insn_ready; push and pop in the same cycle SHALL leave count unchanged.
REQ-019 Full (count == DEPTH): no issue, insn held stable; empty: insn_valid 0, insn/insn_pc don't-care.
REQ-020 Latency: issue in cycle N -> insn_valid in N+2 (no bypass).
REQ-021 Redirect in cycle N SHALL: clear queue, squash response arriving in N, suppress issue in N, load fetch_pc <= {redirect_pc[31:2],2'b00}; first new issue N+1, insn_valid N+3.
REQ-022 Redirect with simultaneous pop SHALL take priority; popped word discarded, no error.
REQ-023 Back-to-back redirects SHALL each restart; only the last redirect_pc is fetched.
REQ-024 Queue pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow.

Reset
REQ-025 rst SHALL set fetch_pc=0, rom_addr=0, count=0, pointers=0, inflight=0, insn_valid=0, insn=0, insn_pc=0.
REQ-026 rst mid-operation SHALL discard queue and in-flight response; first issue (addr 0) in cycle after rst deasserts.
REQ-027 rst SHALL dominate redirect.

Configuration
REQ-028 Macro IFQ_BYPASS_EN SHALL enable bypass; without it REQ-020 latency holds.
REQ-029 With IFQ_BYPASS_EN: empty queue + unsquashed response SHALL drive insn/insn_pc/insn_valid combinationally in the response cycle (issue N -> valid N+1; redirect N -> valid N+2); if insn_ready then high the word SHALL not be enqueued, else enqueued normally.
REQ-030 Issue credit rule (REQ-014) SHALL be identical in both builds.

Verification
REQ-031 Reset release, ROM[i]=0x1000+i, insn_ready=1 -> insn 0x1000@pc 0 valid cycle 2, then 0x1001@4, 0x1002@8 each cycle.
REQ-032 insn_ready=0 for 10 cycles -> exactly DEPTH=4 entries held, no issue once full, pc 0..12 delivered in order on release.
REQ-033 Redirect to 0x40 while queue holds 3 entries -> insn_valid low in N+1, N+2; insn ROM[16]@0x40 valid N+3.
REQ-034 Redirect with redirect_pc=0x43 concurrent with pop -> popped word dropped; next insn_pc=0x40.
REQ-035 Redirect to 0x1FC (ROM_AW=7) -> pcs 0x1FC, 0x200; rom_addr 127 then 0; insn ROM[127], ROM[0].
REQ-036 With IFQ_BYPASS_EN, reset release, insn_ready=1 -> insn 0x1000 valid cycle 1, count stays 0.
